// File: rtl/demux_sequencer.sv
// demux_sequencer
//
// Sequences queued channel requests onto a 1-to-8 demultiplexer. Each request
// {chan, len} is buffered in a DEPTH-entry FIFO. For each request the block
// spends one SETUP cycle driving the channel selects with the strobe low, then
// holds the strobe high for len+1 cycles with the selects frozen.
//
// Optional feature: define DEMUX_SEQUENCER_GAP_EN to insert one strobe-low GAP
// cycle after every ACTIVE period. Without the macro the GAP state is not built.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request offered this cycle
//   req_ready  FIFO can accept (not full)
//   req_chan   target channel 0..7
//   req_len    dwell code, strobe high for req_len+1 cycles
//   out        registered data strobe to the demux data input
//   s0,s1,s2   registered channel select, channel = {s0,s1,s2} (s0 is MSB)
//   busy       sequencer not idle or FIFO non-empty
//   done       high on the final strobe cycle of a request

module demux_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_chan,
    input  logic [3:0] req_len,
    output logic       out,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       busy,
    output logic       done
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StActive = 2'd2;
`ifdef DEMUX_SEQUENCER_GAP_EN
    localparam logic [1:0] StGap    = 2'd3;
`endif

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [6:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [2:0]    head_chan;
    logic [3:0]    head_len;

    assign fifo_full  = (count_q == FullCnt);
    assign fifo_empty = (count_q == '0);
    // Ready depends only on occupancy, so a simultaneous pop never opens a full FIFO.
    assign req_ready  = ~fifo_full;
    assign push       = req_valid & req_ready;
    assign head_chan  = fifo_mem[rd_ptr_q][6:4];
    assign head_len   = fifo_mem[rd_ptr_q][3:0];

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {req_chan, req_len};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [2:0] sel_q;
    logic [2:0] sel_d;
    logic       out_q;
    logic       out_d;
    logic       decide;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pop     = 1'b0;
        decide  = 1'b0;

        case (state_q)
            StIdle: begin
                decide = 1'b1;
            end
            StSetup: begin
                state_d = StActive;
            end
            StActive: begin
                if (cnt_q == 4'd0) begin
`ifdef DEMUX_SEQUENCER_GAP_EN
                    state_d = StGap;
`else
                    decide  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef DEMUX_SEQUENCER_GAP_EN
            StGap: begin
                decide = 1'b1;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // Request boundary: start the next queued request or fall back to idle.
        // Only entries already in the FIFO are considered, so a request pushed
        // on this very edge waits for the following boundary.
        if (decide) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                sel_d   = head_chan;
                cnt_d   = head_len;
                state_d = StSetup;
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Strobe is registered from the next state so it is high exactly in ACTIVE.
    assign out_d = (state_d == StActive);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out  = out_q;
    assign s0   = sel_q[2];
    assign s1   = sel_q[1];
    assign s2   = sel_q[0];
    assign done = (state_q == StActive) && (cnt_q == 4'd0);
    assign busy = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_demux_sequencer.sv
// Self-checking bench for demux_sequencer. The reference model keeps the
// accepted requests as a list of (push cycle, start cycle, chan, len) and
// derives every expected output from the request timeline arithmetic.

module tb_demux_sequencer;

    localparam int DEPTH = 4;
`ifdef DEMUX_SEQUENCER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_chan  = 3'd0;
    logic [3:0] req_len   = 4'd0;
    logic       req_ready;
    logic       out;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: one entry per accepted request.
    int q_p[$];
    int q_s[$];
    int q_ch[$];
    int q_len[$];
    int next_free = 0;

    // Strobe monitor.
    bit       mon_en  = 1'b0;
    int       seen[$];
    int       toggles = 0;
    logic     prev_out = 1'b0;
    logic [2:0] prev_sel = 3'd0;

    always #5 clk = ~clk;

    demux_sequencer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_chan (req_chan),
        .req_len  (req_len),
        .out      (out),
        .s0       (s0),
        .s1       (s1),
        .s2       (s2),
        .busy     (busy),
        .done     (done)
    );

    always @(negedge clk) begin
        if (mon_en) begin
            if (out && !prev_out) seen.push_back(int'({s0, s1, s2}));
            if (out && prev_out && ({s0, s1, s2} != prev_sel)) toggles++;
        end
        prev_out = out;
        prev_sel = {s0, s1, s2};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Entries in the FIFO during cycle k: pushed at or before edge k, not yet popped.
    function automatic int m_occ(input int k);
        int n = 0;
        foreach (q_p[i]) begin
            if (q_p[i] <= k) n++;
            if (q_s[i] <= k) n--;
        end
        return n;
    endfunction

    task automatic check_all();
        int occ;
        int eo = 0;
        int ed = 0;
        int eb = 0;
        int es = 0;
        occ = m_occ(cyc);
        eb  = (occ > 0) ? 1 : 0;
        foreach (q_s[i]) begin
            if (cyc >= q_s[i] + 1 && cyc <= q_s[i] + q_len[i] + 1) eo = 1;
            if (cyc == q_s[i] + q_len[i] + 1) ed = 1;
            if (cyc >= q_s[i] && cyc <= q_s[i] + q_len[i] + 1 + GAP) eb = 1;
            if (q_s[i] <= cyc) es = q_ch[i];
        end
        chk("out", out, eo);
        chk("done", done, ed);
        chk("busy", busy, eb);
        chk("sel", {s0, s1, s2}, es);
        chk("ready", req_ready, (occ < DEPTH) ? 1 : 0);
    endtask

    // Drive one cycle, advance past the rising edge, update the model, check.
    task automatic step(input bit v, input int ch, input int ln, output bit acc);
        int s;
        req_valid = v;
        req_chan  = 3'(ch);
        req_len   = 4'(ln);
        acc = v && (m_occ(cyc) < DEPTH);
        @(posedge clk);
        cyc++;
        if (acc) begin
            s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
            q_p.push_back(cyc);
            q_s.push_back(s);
            q_ch.push_back(ch);
            q_len.push_back(ln);
            next_free = s + ln + 2 + GAP;
        end
        #2;
        check_all();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, a);
    endtask

    // Hold a request valid until accepted, within a cycle budget.
    task automatic push_hold(input int ch, input int ln, output int acc_cyc);
        bit acc = 1'b0;
        int n   = 0;
        acc_cyc = -1;
        while (!acc && n < 64) begin
            step(1'b1, ch, ln, acc);
            n++;
        end
        if (acc) acc_cyc = cyc;
        else chk("push_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rst_out", out, 0);
        chk("rst_sel", {s0, s1, s2}, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        q_p.delete();
        q_s.delete();
        q_ch.delete();
        q_len.delete();
        next_free = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        check_all();
    endtask

    initial begin
        int a;
        int b;
        bit x;

        // Single request: chan 5, len 2 pushed at edge 1.
        do_reset();
        push_hold(5, 2, a);
        chk("single_acc_cyc", a, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 0, 0, x);
            chk("single_out", out, (cyc >= 3 && cyc <= 5) ? 1 : 0);
            chk("single_done", done, (cyc == 5) ? 1 : 0);
            chk("single_busy", busy, (cyc <= 5 + GAP) ? 1 : 0);
            if (cyc >= 2) chk("single_sel", {s0, s1, s2}, 5);
        end

        // Back-to-back same channel, len 0.
        do_reset();
        push_hold(3, 0, a);
        push_hold(3, 0, b);
        chk("b2b_acc", b, 2);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 0, 0, x);
            chk("b2b_out", out, (cyc == 3 || cyc == 5 + GAP) ? 1 : 0);
            chk("b2b_sel", {s0, s1, s2}, 3);
        end

        // Fill while stalled in a long ACTIVE.
        do_reset();
        push_hold(0, 15, a);
        idle(2);
        for (int i = 1; i <= 4; i++) push_hold(i, 1, a);
        chk("fill_fourth_cyc", a, 7);
        chk("fill_ready_low", req_ready, 0);
        push_hold(7, 1, a);
        chk("fill_accept_cyc", a, 20 + GAP);
        idle(60);

        // Channel sweep.
        do_reset();
        seen.delete();
        toggles = 0;
        mon_en  = 1'b1;
        for (int ch = 0; ch < 8; ch++) push_hold(ch, 0, a);
        idle(30);
        mon_en = 1'b0;
        chk("sweep_count", seen.size(), 8);
        chk("sweep_toggles", toggles, 0);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("sweep_order", seen[i], i);

        // Reset while ACTIVE with requests still queued.
        do_reset();
        push_hold(6, 5, a);
        push_hold(2, 3, a);
        push_hold(1, 3, a);
        a = 0;
        while (!out && a < 20) begin
            step(1'b0, 0, 0, x);
            a++;
        end
        chk("midrst_reached_active", out, 1);
        idle(1);
        do_reset();
        seen.delete();
        mon_en = 1'b1;
        idle(20);
        mon_en = 1'b0;
        chk("midrst_no_pulses", seen.size(), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", req_ready, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 5)), x);
        end
        idle(80);
        chk("random_drained_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
